// File: rtl/pll_ideal_pkg.sv
// Shared types and constants for the ideal-PLL blocks.
package pll_ideal_pkg;

    // Phase-frequency detector FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } pfd_state_e;

    // Largest positive magnitude a signed ERR_WIDTH-bit value can hold
    function automatic int unsigned err_sat_max(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/pfd_sampled_edge_sync.sv
// Multi-flop synchronizer for an asynchronous clock-as-data input, followed
// by a delay flop and a rising-edge detector.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Synchronizer chain plus one delay flop for the edge compare
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // Rise is combinational so the FSM registers it on the following edge
    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/pfd_sampled.sv
// Sampled phase-frequency detector: oversamples the reference and divided
// feedback clocks on clk, drives UP/DN, and measures edge-to-edge phase error
// in clk cycles. Optional lock detector under macro PFD_LOCK_DETECT_EN;
// without it, locked is tied low.
module pfd_sampled
    import pll_ideal_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_WIDTH   = 16,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ref_clk_digital,
    input  logic                        fb_clk_digital,
    output logic                        up,
    output logic                        dn,
    output logic signed [ERR_WIDTH-1:0] phase_err,
    output logic                        phase_err_valid,
    output logic                        locked
);

    localparam logic [ERR_WIDTH-1:0] CNT_MAX = ERR_WIDTH'(err_sat_max(ERR_WIDTH));
    localparam logic [ERR_WIDTH-1:0] CNT_ONE = ERR_WIDTH'(1);

    logic ref_rise, fb_rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ref_clk_digital),
        .rise  (ref_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .clk   (clk),
        .reset (reset),
        .d     (fb_clk_digital),
        .rise  (fb_rise)
    );

    pfd_state_e                  state_q, state_d;
    logic [ERR_WIDTH-1:0]        cnt_q, cnt_d, cnt_inc;
    logic signed [ERR_WIDTH-1:0] err_q, err_d;
    logic [ERR_WIDTH-1:0]        mag_d;
    logic                        vld_q, vld_d;
    logic                        up_q, dn_q;

    // Saturating increment: a long slip must clamp, never wrap to negative
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Next-state, counter and measurement capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        err_d   = err_q;
        mag_d   = '0;
        vld_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ref_rise && fb_rise) begin
                    err_d = '0;
                    vld_d = 1'b1;
                end else if (ref_rise) begin
                    state_d = UP;
                    cnt_d   = CNT_ONE;
                end else if (fb_rise) begin
                    state_d = DN;
                    cnt_d   = CNT_ONE;
                end
            end
            UP: begin
                // A lone ref rise is a cycle slip: keep counting
                if (fb_rise) begin
                    err_d = $signed(cnt_q);
                    mag_d = cnt_q;
                    vld_d = 1'b1;
                    if (ref_rise) cnt_d = CNT_ONE;
                    else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            DN: begin
                if (ref_rise) begin
                    err_d = -$signed(cnt_q);
                    mag_d = cnt_q;
                    vld_d = 1'b1;
                    if (fb_rise) cnt_d = CNT_ONE;
                    else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            vld_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            up_q    <= (state_d == UP);
            dn_q    <= (state_d == DN);
        end
    end

    assign up              = up_q;
    assign dn              = dn_q;
    assign phase_err       = err_q;
    assign phase_err_valid = vld_q;

`ifdef PFD_LOCK_DETECT_EN
    localparam int LCW = $clog2(LOCK_COUNT + 1);
    localparam logic [LCW-1:0] LC_MAX = LCW'(LOCK_COUNT);

    logic [LCW-1:0] lock_cnt_q;
    logic           locked_q;
    logic           in_tol;

    assign in_tol = (int'(mag_d) <= LOCK_TOL);

    // Lock tracking updates on the same edge that publishes the measurement
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else if (vld_d) begin
            if (in_tol) begin
                if (lock_cnt_q != LC_MAX) lock_cnt_q <= lock_cnt_q + LCW'(1);
                locked_q <= (lock_cnt_q >= LC_MAX - LCW'(1));
            end else begin
                lock_cnt_q <= '0;
                locked_q   <= 1'b0;
            end
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_sampled.sv
// Self-checking bench for pfd_sampled: a default-width instance and a 4-bit
// instance share stimulus; a timestamp-based model predicts every output.
module tb_pfd_sampled;

    logic clk = 1'b0;
    logic reset, ref_in, fb_in;

    logic              up16, dn16, v16, l16;
    logic signed [15:0] pe16;
    logic              up4, dn4, v4, l4;
    logic signed [3:0]  pe4;

    always #5 clk = ~clk;

    pfd_sampled u_d16 (
        .clk(clk), .reset(reset), .ref_clk_digital(ref_in), .fb_clk_digital(fb_in),
        .up(up16), .dn(dn16), .phase_err(pe16), .phase_err_valid(v16), .locked(l16)
    );

    pfd_sampled #(.ERR_WIDTH(4)) u_d4 (
        .clk(clk), .reset(reset), .ref_clk_digital(ref_in), .fb_clk_digital(fb_in),
        .up(up4), .dn(dn4), .phase_err(pe4), .phase_err_valid(v4), .locked(l4)
    );

`ifdef PFD_LOCK_DETECT_EN
    localparam int LOCK_EXP = 1;
`else
    localparam int LOCK_EXP = 0;
`endif

    int nvec = 0;
    int nfail = 0;
    int k = 0;
    bit mchk = 1'b0;

    task automatic chk(input string nm, input integer act, input integer exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, k);
        end
    endtask

    // Model: an open measurement is a direction plus the edge index it began
    int sat_m [2] = '{32767, 7};
    int open_m[2], o_m[2], err_m[2], lc_m[2];
    bit vld_m[2], lck_m[2];
    bit ra1, ra2, fa1, fa2, rr, fr;

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            vld_m[m] = 1'b0;
            if (reset) begin
                open_m[m] = 0; err_m[m] = 0; lc_m[m] = 0; lck_m[m] = 1'b0;
            end else begin
                if (open_m[m] == 0) begin
                    if (rr && fr) begin err_m[m] = 0; vld_m[m] = 1'b1; end
                    else if (rr) begin open_m[m] = 1;  o_m[m] = k; end
                    else if (fr) begin open_m[m] = -1; o_m[m] = k; end
                end else if (open_m[m] == 1 && fr) begin
                    err_m[m] = (k - o_m[m] > sat_m[m]) ? sat_m[m] : k - o_m[m];
                    vld_m[m] = 1'b1;
                    if (rr) o_m[m] = k; else open_m[m] = 0;
                end else if (open_m[m] == -1 && rr) begin
                    err_m[m] = -((k - o_m[m] > sat_m[m]) ? sat_m[m] : k - o_m[m]);
                    vld_m[m] = 1'b1;
                    if (fr) o_m[m] = k; else open_m[m] = 0;
                end
`ifdef PFD_LOCK_DETECT_EN
                if (vld_m[m]) begin
                    if (err_m[m] <= 2 && err_m[m] >= -2) begin
                        if (lc_m[m] < 8) lc_m[m]++;
                    end else lc_m[m] = 0;
                    lck_m[m] = (lc_m[m] == 8);
                end
`endif
            end
        end
        // A rise is seen by the FSM one edge after the second sample of a new high
        rr  = !reset && ra1 && !ra2;
        fr  = !reset && fa1 && !fa2;
        ra2 = ra1; ra1 = reset ? 1'b0 : ref_in;
        fa2 = fa1; fa1 = reset ? 1'b0 : fb_in;
        k++;
        mchk = 1'b1;
    end

    int upc[2], dnc[2], vc[2], lerr[2];

    // Per-cycle comparison against the model plus activity tallies
    always @(negedge clk) begin
        if (mchk) begin
            chk("up16",   up16, integer'(open_m[0] == 1));
            chk("dn16",   dn16, integer'(open_m[0] == -1));
            chk("vld16",  v16,  integer'(vld_m[0]));
            chk("err16",  integer'(pe16), err_m[0]);
            chk("lock16", l16,  integer'(lck_m[0]));
            chk("up4",    up4,  integer'(open_m[1] == 1));
            chk("dn4",    dn4,  integer'(open_m[1] == -1));
            chk("vld4",   v4,   integer'(vld_m[1]));
            chk("err4",   integer'(pe4), err_m[1]);
            chk("lock4",  l4,   integer'(lck_m[1]));
            if (up16) upc[0]++;
            if (dn16) dnc[0]++;
            if (v16) begin vc[0]++; lerr[0] = int'(pe16); end
            if (up4) upc[1]++;
            if (dn4) dnc[1]++;
            if (v4) begin vc[1]++; lerr[1] = int'(pe4); end
        end
    end

    int s_up[2], s_dn[2], s_vc[2];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int m = 0; m < 2; m++) begin
            s_up[m] = upc[m]; s_dn[m] = dnc[m]; s_vc[m] = vc[m];
        end
    endtask

    // Ref rises dref cycles from now, fb rises dfb cycles from now
    task automatic meas(input int dref, input int dfb);
        int mx;
        mx = (dref > dfb) ? dref : dfb;
        for (int t = 0; t <= mx + 2; t++) begin
            ref_in = (t >= dref);
            fb_in  = (t >= dfb);
            step(1);
        end
        ref_in = 1'b0; fb_in = 1'b0;
        step(8);
    endtask

    initial begin
        reset = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
        // Reset held with toggling inputs
        for (int i = 0; i < 5; i++) begin
            ref_in = i[0]; fb_in = !i[0];
            step(1);
        end
        ref_in = 1'b0; fb_in = 1'b0;
        step(1);
        reset = 1'b0;
        step(10);
        chk("rst_up", upc[0] + upc[1], 0);
        chk("rst_dn", dnc[0] + dnc[1], 0);
        chk("rst_vld", vc[0] + vc[1], 0);

        // Ref leads by 5
        snap(); meas(0, 5);
        chk("rl_up",  upc[0] - s_up[0], 5);
        chk("rl_dn",  dnc[0] - s_dn[0], 0);
        chk("rl_vc",  vc[0] - s_vc[0], 1);
        chk("rl_err", lerr[0], 5);

        // Fb leads by 3
        snap(); meas(3, 0);
        chk("fl_dn",  dnc[0] - s_dn[0], 3);
        chk("fl_up",  upc[0] - s_up[0], 0);
        chk("fl_vc",  vc[0] - s_vc[0], 1);
        chk("fl_err", lerr[0], -3);

        // Simultaneous edges
        snap(); meas(0, 0);
        chk("sim_updn", (upc[0] - s_up[0]) + (dnc[0] - s_dn[0]), 0);
        chk("sim_vc",   vc[0] - s_vc[0], 1);
        chk("sim_err",  lerr[0], 0);

        // Cycle slip: ref at 0 and 6, fb at 20; 4-bit instance saturates
        snap();
        for (int t = 0; t <= 22; t++) begin
            ref_in = (t < 3) || (t >= 6);
            fb_in  = (t >= 20);
            step(1);
        end
        ref_in = 1'b0; fb_in = 1'b0;
        step(8);
        chk("slip_up4",  upc[1] - s_up[1], 20);
        chk("slip_vc4",  vc[1] - s_vc[1], 1);
        chk("slip_err4", lerr[1], 7);
        chk("slip_err16", lerr[0], 20);

        // Slip aborted by reset mid-measurement
        snap();
        for (int t = 0; t <= 12; t++) begin
            ref_in = (t < 3) || (t >= 6 && t < 9);
            fb_in  = 1'b0;
            reset  = (t == 10);
            step(1);
        end
        reset = 1'b0;
        step(10);
        chk("rs_up4", upc[1] - s_up[1], 8);
        chk("rs_up16", upc[0] - s_up[0], 8);
        chk("rs_vc",  (vc[0] - s_vc[0]) + (vc[1] - s_vc[1]), 0);

        // Lock: alternating +1 / -2 measurements
        for (int i = 0; i < 8; i++) begin
            if (i[0]) meas(2, 0); else meas(0, 1);
            if (i == 6) chk("lock_7th", l16, 0);
        end
        chk("lock_err8", lerr[0], -2);
        chk("lock_8th16", l16, LOCK_EXP);
        chk("lock_8th4",  l4,  LOCK_EXP);
        meas(0, 5);
        chk("unlock_err", lerr[0], 5);
        chk("unlock16", l16, 0);
        chk("unlock4",  l4,  0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
